// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO device-select controller.
package mmio_pkg;

    localparam int unsigned DEV_SEL_W     = 3;
    localparam int unsigned NUM_DEV       = 8;
    localparam logic [15:0] BASE_ADDR_DEF = 16'hC000;
    localparam int unsigned TIMEOUT_DEF   = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Saturating ACCESS-cycle counter; tc_c flags the last permitted wait cycle.
module mmio_timeout_ctr
    import mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Saturates at TIMEOUT so it can never wrap back into range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(TIMEOUT))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc_c = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mmio_dev_sel_ctrl.sv
// Single-outstanding MMIO request controller driving the 3-to-8 select decoder,
// with window check, device-ready wait, timeout and one-cycle ack.
module mmio_dev_sel_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
    parameter int unsigned       TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 ack,
    output logic                 err,
    output logic [DATA_W-1:0]    rdata,
    output logic                 busy,
    output logic [DEV_SEL_W-1:0] dev_adr,
    output logic                 dev_en,
    output logic                 dev_we,
    output logic [DATA_W-1:0]    dev_wdata,
    input  logic                 dev_rdy,
    input  logic [DATA_W-1:0]    dev_rdata
);

    state_t               state, state_d;
    logic                 ack_d, err_d, busy_d, dev_en_d, dev_we_d;
    logic [DATA_W-1:0]    rdata_d, dev_wdata_d;
    logic [DEV_SEL_W-1:0] dev_adr_d;
    logic                 hit;
    logic                 ctr_clear;
    logic                 ctr_tc;

    assign hit = (addr[ADDR_W-1:DEV_SEL_W] == BASE_ADDR[ADDR_W-1:DEV_SEL_W]);

    mmio_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (ctr_clear),
        .enable (state == ST_ACCESS),
        .tc_c   (ctr_tc)
    );

    // Next-state and next-output logic; every register has a hold default.
    always_comb begin
        state_d     = state;
        ack_d       = 1'b0;
        err_d       = err;
        rdata_d     = rdata;
        busy_d      = busy;
        dev_adr_d   = dev_adr;
        dev_en_d    = dev_en;
        dev_we_d    = dev_we;
        dev_wdata_d = dev_wdata;
        ctr_clear   = 1'b0;

        case (state)
            ST_IDLE: begin
                ctr_clear = 1'b1;
                if (req) begin
                    dev_adr_d   = addr[DEV_SEL_W-1:0];
                    dev_wdata_d = wdata;
                    busy_d      = 1'b1;
                    if (hit) begin
                        state_d  = ST_ACCESS;
                        dev_en_d = 1'b1;
                        dev_we_d = we;
                    end else begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready beats timeout when both land in the same cycle.
                if (dev_rdy) begin
                    state_d  = ST_RESP;
                    ack_d    = 1'b1;
                    err_d    = 1'b0;
                    rdata_d  = dev_we ? '0 : dev_rdata;
                    dev_en_d = 1'b0;
                    dev_we_d = 1'b0;
                end else if (ctr_tc) begin
                    state_d  = ST_RESP;
                    ack_d    = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    dev_en_d = 1'b0;
                    dev_we_d = 1'b0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                err_d    = 1'b0;
                rdata_d  = '0;
                busy_d   = 1'b0;
                dev_en_d = 1'b0;
                dev_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            dev_adr   <= '0;
            dev_en    <= 1'b0;
            dev_we    <= 1'b0;
            dev_wdata <= '0;
        end else begin
            state     <= state_d;
            ack       <= ack_d;
            err       <= err_d;
            rdata     <= rdata_d;
            busy      <= busy_d;
            dev_adr   <= dev_adr_d;
            dev_en    <= dev_en_d;
            dev_we    <= dev_we_d;
            dev_wdata <= dev_wdata_d;
        end
    end

endmodule

// File: tb/tb_mmio_dev_sel_ctrl.sv
// Randomized bench for mmio_dev_sel_ctrl against a transaction-level reference model.
module tb_mmio_dev_sel_ctrl;

    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned BASE    = 32'h0000_C000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, dev_rdy;
    logic [15:0] addr, wdata, dev_rdata;
    logic        ack, err, busy, dev_en, dev_we;
    logic [15:0] rdata, dev_wdata;
    logic [2:0]  dev_adr;

    int total = 0;
    int bad   = 0;

    mmio_dev_sel_ctrl #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .BASE_ADDR (16'hC000),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .dev_adr   (dev_adr),
        .dev_en    (dev_en),
        .dev_we    (dev_we),
        .dev_wdata (dev_wdata),
        .dev_rdy   (dev_rdy),
        .dev_rdata (dev_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          en;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    typedef struct {
        int          lat;
        int          en;
        logic        err;
        logic [15:0] rdata;
        logic [2:0]  adr;
        logic [15:0] dwdata;
        bit          busy_ok;
        bit          en_ok;
        bit          clear_ok;
    } obs_t;

    // Reference: window is BASE..BASE+7; rdy_at = ACCESS cycle that sees ready (0 = never).
    function automatic exp_t model(input logic [15:0] a, input logic w, input int rdy_at,
                                   input logic [15:0] drd);
        exp_t        e;
        int unsigned ai;
        ai = a;
        if (!(ai >= BASE && ai < BASE + 8)) begin
            e.lat = 1; e.en = 0; e.err = 1'b1; e.rdata = 16'h0;
        end else if (rdy_at >= 1 && rdy_at <= int'(TIMEOUT)) begin
            e.lat = rdy_at + 1; e.en = rdy_at; e.err = 1'b0; e.rdata = w ? 16'h0 : drd;
        end else begin
            e.lat = int'(TIMEOUT) + 1; e.en = int'(TIMEOUT); e.err = 1'b1; e.rdata = 16'h0;
        end
        return e;
    endfunction

    // Starts and ends on a negedge; the final negedge is the cycle after ack.
    task automatic do_txn(input logic [15:0] a, input logic w, input logic [15:0] wd,
                          input int rdy_at, input logic [15:0] drd, input bit toggle,
                          output obs_t o);
        int  n   = 0;
        int  acc = 0;
        bit  done = 0;
        req = 1'b1; we = w; addr = a; wdata = wd; dev_rdata = drd; dev_rdy = 1'b0;
        o.lat = -1; o.err = 1'bx; o.rdata = 'x; o.adr = 'x; o.dwdata = 'x;
        o.busy_ok = 1; o.en_ok = 1; o.clear_ok = 1;
        while (!done && n < 40) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (busy !== 1'b1) o.busy_ok = 0;
            if (dev_en === 1'b1) begin
                acc++;
                if (dev_adr !== a[2:0] || dev_we !== w || dev_wdata !== wd) o.en_ok = 0;
            end
            if (ack === 1'b1) begin
                o.lat = n; o.err = err; o.rdata = rdata; o.adr = dev_adr; o.dwdata = dev_wdata;
                done = 1; req = 1'b0; dev_rdy = 1'b0;
            end else begin
                dev_rdy = (dev_en === 1'b1) ? (rdy_at != 0 && acc == rdy_at) : 1'($urandom);
                if (toggle) req = 1'($urandom);
            end
        end
        o.en = acc;
        @(posedge clk);
        @(negedge clk);
        o.clear_ok = (ack === 1'b0) && (err === 1'b0) && (rdata === 16'h0) &&
                     (busy === 1'b0) && (dev_en === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0;
        dev_rdy = 1'b0; dev_rdata = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ack, err, busy, dev_en, dev_we} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000", {ack, err, busy, dev_en, dev_we});
        end
        total++;
        if (rdata !== 16'h0 || dev_wdata !== 16'h0 || dev_adr !== 3'h0) begin
            bad++; $display("FAIL reset_data: got rdata=%h dev_wdata=%h dev_adr=%0d want 0",
                            rdata, dev_wdata, dev_adr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int acks = 0;
        req = 1'b1; we = 1'b0; addr = 16'hC001; dev_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (dev_en !== 1'b1) begin
            bad++; $display("FAIL midrst_en: got dev_en=%b want 1", dev_en);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ack, err, busy, dev_en, dev_we} !== 5'b0 || rdata !== 16'h0 || dev_adr !== 3'h0) begin
            bad++; $display("FAIL midrst_async: got ctrl=%b rdata=%h adr=%0d want 0",
                            {ack, err, busy, dev_en, dev_we}, rdata, dev_adr);
        end
        @(negedge clk); req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ack === 1'b1 || busy === 1'b1) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++; $display("FAIL midrst_noack: got %0d ack/busy cycles want 0", acks);
        end
    endtask

    task automatic test_read();
        obs_t o;
        do_txn(16'hC005, 1'b0, 16'h5555, 1, 16'hBEEF, 0, o);
        total++;
        if (o.lat != 2 || o.en != 1) begin
            bad++; $display("FAIL read_timing: got lat=%0d en=%0d want lat=2 en=1", o.lat, o.en);
        end
        total++;
        if (o.rdata !== 16'hBEEF || o.err !== 1'b0 || o.adr !== 3'd5) begin
            bad++; $display("FAIL read_data: got rdata=%h err=%b adr=%0d want BEEF 0 5",
                            o.rdata, o.err, o.adr);
        end
        total++;
        if (!(o.en_ok && o.busy_ok && o.clear_ok)) begin
            bad++; $display("FAIL read_flags: got en_ok=%0d busy_ok=%0d clear_ok=%0d want 1 1 1",
                            o.en_ok, o.busy_ok, o.clear_ok);
        end
    endtask

    task automatic test_write();
        obs_t o;
        do_txn(16'hC002, 1'b1, 16'h1234, 3, 16'hFFFF, 0, o);
        total++;
        if (o.lat != 4 || o.en != 3) begin
            bad++; $display("FAIL write_timing: got lat=%0d en=%0d want lat=4 en=3", o.lat, o.en);
        end
        total++;
        if (o.rdata !== 16'h0 || o.err !== 1'b0 || o.dwdata !== 16'h1234 || !o.en_ok) begin
            bad++; $display("FAIL write_data: got rdata=%h err=%b dwdata=%h en_ok=%0d want 0 0 1234 1",
                            o.rdata, o.err, o.dwdata, o.en_ok);
        end
    endtask

    task automatic test_miss();
        obs_t o;
        do_txn(16'hC008, 1'b0, 16'hAAAA, 1, 16'h7777, 0, o);
        total++;
        if (o.lat != 1 || o.en != 0 || o.err !== 1'b1 || o.rdata !== 16'h0) begin
            bad++; $display("FAIL miss: got lat=%0d en=%0d err=%b rdata=%h want 1 0 1 0",
                            o.lat, o.en, o.err, o.rdata);
        end
        total++;
        if (o.adr !== 3'd0 || !o.clear_ok) begin
            bad++; $display("FAIL miss_post: got adr=%0d clear_ok=%0d want 0 1", o.adr, o.clear_ok);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_txn(16'hC007, 1'b0, 16'h0, 0, 16'h9999, 0, o);
        total++;
        if (o.lat != 16 || o.en != 15 || o.err !== 1'b1 || o.rdata !== 16'h0) begin
            bad++; $display("FAIL timeout: got lat=%0d en=%0d err=%b rdata=%h want 16 15 1 0",
                            o.lat, o.en, o.err, o.rdata);
        end
        do_txn(16'hC003, 1'b0, 16'h0, 15, 16'h4321, 0, o);
        total++;
        if (o.lat != 16 || o.err !== 1'b0 || o.rdata !== 16'h4321) begin
            bad++; $display("FAIL rdy_at_timeout: got lat=%0d err=%b rdata=%h want 16 0 4321",
                            o.lat, o.err, o.rdata);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        logic [15:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 16'hC000 + 16'(i);
            e = model(a, 1'(i), i + 1, 16'hA000 + 16'(i));
            do_txn(a, 1'(i), 16'h3000 + 16'(i), i + 1, 16'hA000 + 16'(i), 1, o);
            total++;
            if (o.lat != e.lat || o.en != e.en || o.err !== e.err || o.rdata !== e.rdata ||
                !o.clear_ok || !o.busy_ok) begin
                bad++; $display("FAIL b2b[%0d]: got lat=%0d en=%0d err=%b rdata=%h clr=%0d busy=%0d want lat=%0d en=%0d err=%b rdata=%h",
                                i, o.lat, o.en, o.err, o.rdata, o.clear_ok, o.busy_ok,
                                e.lat, e.en, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic [15:0] a, wd, drd;
        logic        w;
        int          rdy_at;
        for (int i = 0; i < 60; i++) begin
            a      = ($urandom_range(0, 3) != 0) ? 16'(BASE - 4 + $urandom_range(0, 15))
                                                 : 16'($urandom);
            w      = 1'($urandom);
            wd     = 16'($urandom);
            drd    = 16'($urandom);
            rdy_at = $urandom_range(0, 18);
            e = model(a, w, rdy_at, drd);
            do_txn(a, w, wd, rdy_at, drd, 1'($urandom), o);
            total++;
            if (o.lat != e.lat || o.en != e.en || o.err !== e.err || o.rdata !== e.rdata) begin
                bad++; $display("FAIL rand[%0d] a=%h w=%b rdy_at=%0d: got lat=%0d en=%0d err=%b rdata=%h want lat=%0d en=%0d err=%b rdata=%h",
                                i, a, w, rdy_at, o.lat, o.en, o.err, o.rdata,
                                e.lat, e.en, e.err, e.rdata);
            end
            total++;
            if (o.adr !== a[2:0] || o.dwdata !== wd || !o.en_ok || !o.busy_ok || !o.clear_ok) begin
                bad++; $display("FAIL rand_side[%0d]: got adr=%0d dwdata=%h en_ok=%0d busy_ok=%0d clr=%0d want adr=%0d dwdata=%h 1 1 1",
                                i, o.adr, o.dwdata, o.en_ok, o.busy_ok, o.clear_ok, a[2:0], wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_miss();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
